// File: rtl/score_tracker.sv
// Score keeper for the two-digit 7-segment display: counts rounds, saturates, and strobes display loads.
// Optional SCORE_HISCORE_EN adds high-score latching and the game-over final/high alternation.
module score_tracker #(
  parameter int MAX_SCORE   = 99,
  parameter int SHOW_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       correct,
  input  logic       wrong,
  output logic [7:0] number,
  output logic       change_score,
  output logic       playing,
  output logic       showing_high,
  output logic [7:0] high_score
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;
  localparam logic [7:0] MAX    = 8'(MAX_SCORE);

  logic [1:0] state;
  logic [7:0] score;

`ifdef SCORE_HISCORE_EN
  localparam int          CW   = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SHOW_CYCLES - 1);

  logic [CW-1:0] phase;
  logic          show_q;
  logic [7:0]    hs_q;

  assign showing_high = show_q;
  assign high_score   = hs_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^(32'(SHOW_CYCLES));
  assign showing_high = 1'b0;
  assign high_score   = 8'd0;
`endif

  assign playing = (state == S_PLAY);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= S_IDLE;
      score        <= 8'd0;
      number       <= 8'd0;
      change_score <= 1'b0;
`ifdef SCORE_HISCORE_EN
      phase        <= '0;
      show_q       <= 1'b0;
      hs_q         <= 8'd0;
`endif
    end else begin
      change_score <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            score        <= 8'd0;
            number       <= 8'd0;
            change_score <= 1'b1;
            state        <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (start) begin
            score        <= 8'd0;
            number       <= 8'd0;
            change_score <= 1'b1;
          end else if (wrong) begin
            // number already carries the final score, so no reload strobe
            state <= S_OVER;
`ifdef SCORE_HISCORE_EN
            phase  <= '0;
            show_q <= 1'b0;
            if (score > hs_q) hs_q <= score;
`endif
          end else if (correct && score < MAX) begin
            score        <= score + 8'd1;
            number       <= score + 8'd1;
            change_score <= 1'b1;
          end
        end
        S_OVER: begin
          if (start) begin
            score        <= 8'd0;
            number       <= 8'd0;
            change_score <= 1'b1;
            state        <= S_PLAY;
`ifdef SCORE_HISCORE_EN
            show_q       <= 1'b0;
`endif
          end
`ifdef SCORE_HISCORE_EN
          else if (phase == LAST) begin
            phase        <= '0;
            show_q       <= ~show_q;
            number       <= show_q ? score : hs_q;
            change_score <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker (MAX_SCORE=5, SHOW_CYCLES=4); adapts to SCORE_HISCORE_EN.
module tb_score_tracker;

  logic       clock = 1'b0;
  logic       resetn, start, correct, wrong;
  logic [7:0] number, high_score;
  logic       change_score, playing, showing_high;

  int checks = 0;
  int failures = 0;

  score_tracker #(.MAX_SCORE(5), .SHOW_CYCLES(4)) dut (
    .clock(clock), .resetn(resetn), .start(start), .correct(correct), .wrong(wrong),
    .number(number), .change_score(change_score), .playing(playing),
    .showing_high(showing_high), .high_score(high_score)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rn, s, c, w;
    logic [7:0] num;
    logic       ch, pl;
  } vec_t;

  vec_t tv[23];

`ifdef SCORE_HISCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drive one cycle of inputs, then sample just after the rising edge
  task automatic cyc(input logic rn, input logic s, input logic c, input logic w);
    @(negedge clock);
    resetn = rn; start = s; correct = c; wrong = w;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string name, input int num, input int ch, input int pl,
                         input int sh, input int hs);
    chk({name, ".number"}, number, num);
    chk({name, ".change"}, change_score, ch);
    chk({name, ".playing"}, playing, pl);
    chk({name, ".showing_high"}, showing_high, sh);
    chk({name, ".high_score"}, high_score, hs);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; correct = 1'b0; wrong = 1'b0;

    tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b1};
    tv[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b1};
    tv[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b1};
    tv[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b1};
    tv[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b1};
    tv[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1};
    tv[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1};
    tv[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1};
    tv[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b1};
    tv[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b1};
    tv[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0};
    tv[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0};
    tv[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0};
    tv[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1};

    for (int i = 0; i < 23; i++) begin
      cyc(tv[i].rn, tv[i].s, tv[i].c, tv[i].w);
      chk($sformatf("vec%0d.number", i), number, tv[i].num);
      chk($sformatf("vec%0d.change", i), change_score, tv[i].ch);
      chk($sformatf("vec%0d.playing", i), playing, tv[i].pl);
      if (i == 0) chk("vec0.high_score", high_score, 0);
    end
    // score 4 ended the first game
    chk("table.high_score", high_score, HS ? 4 : 0);

    // fresh game: score 3 then wrong
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("rst1", 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk($sformatf("g1.step%0d", k), number, k + 1);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk_out("g1.over", 3, 0, 0, 0, HS ? 3 : 0);

    // second game: score 2 does not beat 3
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk_out("g2.start", 0, 1, 1, 0, HS ? 3 : 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk_out("g2.over", 2, 0, 0, 0, HS ? 3 : 0);

    begin
      logic sh;
      int   pulses;
      sh = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
        cyc(1'b1, 1'b0, (k == 2), (k == 5));
        if (HS && (k % 4 == 0)) sh = ~sh;
        if (change_score) pulses++;
        chk($sformatf("alt%0d", k), {number, change_score, showing_high, playing},
            {(sh ? 8'd3 : 8'd2), (HS && (k % 4 == 0)), sh, 1'b0});
      end
      chk("alt.pulses", pulses, HS ? 5 : 0);
    end

    // mid-game-over reset returns everything to reset values
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("rst2", 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_out("rst2.idle", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
